// File: rtl/fifo_write_ctrl.sv
// Write-side controller for the dual-clock FIFO: handshake, write pointers, read-pointer sync,
// full / fill level / sticky overflow. Define FIFO_WR_ALMOST_FULL_EN to add the almost_full output.
module fifo_write_ctrl #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic              write_clk,
  input  logic              write_rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W:0]   read_ptr_gray,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W:0]   write_addr,
  output logic              write_enable_1,
  output logic [ADDR_W:0]   write_ptr_gray,
  output logic              full,
  output logic [ADDR_W:0]   fill_level,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic              almost_full,
`endif
  output logic              overflow
);

  localparam int unsigned PtrW = ADDR_W + 1;

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] rq1_q, rq2_q;
  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] fill_q, fill_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            we;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= int'(ADDR_W); i++) begin
      rbin_s[i] = ^(rq2_q >> i);
    end
  end

  always_comb begin
    we      = wr_valid & ~full_q;
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, we};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the write pointer is one lap ahead of the synchronised read pointer.
    full_d  = (wgray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
    fill_d  = wbin_d - rbin_s;
    ovf_d   = ovf_q;
    if (wr_valid && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= read_ptr_gray;
      rq2_q   <= rq1_q;
      fill_q  <= fill_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AfLevel = PtrW'(AF_LEVEL);

  logic af_q, af_d;

  always_comb begin
    af_d = (fill_d >= AfLevel);
  end

  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full = af_q;
`endif

  assign wr_ready       = ~full_q;
  assign write_data     = wr_data;
  assign write_addr     = wbin_q;
  assign write_enable_1 = we;
  assign write_ptr_gray = wgray_q;
  assign full           = full_q;
  assign fill_level     = fill_q;
  assign overflow       = ovf_q;

endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Write-side controller for the 8-entry dual-clock FIFO, directly upstream of the FIFO storage array. Accepts producer words through a valid/ready handshake, then drives the storage array's write data, write address and write enable. Maintains the binary and Gray write pointers and synchronises the read-domain Gray pointer into `write_clk`. Derives full, fill level, optional almost-full, and a sticky overflow flag.

## Interface
- `ADDR_W`, 3: storage index width; depth = 2^ADDR_W = 8; pointers are ADDR_W+1 bits, MSB = wrap bit
- `DATA_W`, 8: word width
- `AF_LEVEL`, 6: almost-full threshold in entries (1..2^ADDR_W)
- `write_clk`  in  1  write-domain clock
- `write_rst`  in  1  reset write_rst, asynchronous, active-low; clock write_clk
- `wr_valid`  in  1  producer offers `wr_data`
- `wr_data`  in  DATA_W  producer word
- `wr_ready`  out  1  = !full
- `read_ptr_gray`  in  ADDR_W+1  read pointer, Gray code, read-clock domain
- `ovf_clr`  in  1  clears `overflow`
- `write_data`  out  DATA_W  to storage; combinational copy of `wr_data`
- `write_addr`  out  ADDR_W+1  binary write pointer; storage uses [ADDR_W-1:0]
- `write_enable_1`  out  1  = wr_valid & !full, combinational
- `write_ptr_gray`  out  ADDR_W+1  registered Gray write pointer, to read domain
- `full`  out  1  registered
- `fill_level`  out  ADDR_W+1  registered occupancy, 0..8
- `almost_full`  out  1  registered; present only with macro
- `overflow`  out  1  sticky write-while-full error

## Operation
- Accepted write occurs when `write_enable_1` = 1 at a rising edge. On an accepted write, `wbin` is incremented modulo 2^(ADDR_W+1). `write_ptr_gray` <= next_bin ^ (next_bin >> 1).
- Read pointer sync: two flops, `rq1` then `rq2`, both reset to 0. No logic between the two flops. `rbin_s` = gray-to-binary(`rq2`).
- Full: `full` <= (gray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}), where gray_next is the post-increment Gray pointer.
- Fill level: `fill_level` <= (bin_next − rbin_s) mod 2^(ADDR_W+1). It is pessimistic, because the read pointer lags.
- Overflow: `overflow` is set on any edge with `wr_valid` & `full`. It holds until an edge with `ovf_clr` = 1. Set has priority over clear on the same edge.
- When `full` = 1, the pointers, `full` and `fill_level` change only through `rq2` movement.
- Reset values of all registers and outputs are 0: `wbin`, `write_ptr_gray`, `rq1`, `rq2`, `full`, `fill_level`, `almost_full`, `overflow`.
- Assertion of `write_rst` mid-operation clears all state immediately. Any write in that cycle is discarded. The read domain must be reset together with the write domain.

## Timing
- Write latency: data lands in storage on the same edge as the handshake. `write_addr` advances on that edge.
- `full` rises on the edge of the 8th outstanding write. `write_enable_1` drops combinationally in the following cycle.
- Read-pointer change is stable before edge N. It reaches `rq1` at N and `rq2` at N+1. `full` and `fill_level` reflect it after edge N+2.
- `write_ptr_gray` changes at most one bit per edge, for CDC safety.
- Wrap-around: after write 16 with no full stall, `write_addr` returns to 0 and `write_ptr_gray` returns to 0.

## Configuration
- `FIFO_WR_ALMOST_FULL_EN` defined:
  - `almost_full` port exists.
  - `almost_full` <= (bin_next − rbin_s) >= AF_LEVEL, same timing as `fill_level`.
- Macro undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: pulse `write_rst` low mid-run, asynchronously -> all outputs 0 immediately, before any clock edge; `wr_ready` = 1.
- Fill: `read_ptr_gray` = 0, 8 back-to-back writes 0x11..0x88 -> after 8th edge: `full` = 1, `write_addr` = 4'b1000, `write_ptr_gray` = 4'b1100, `fill_level` = 8, `almost_full` = 1 (from the 6th write).
- Overflow: while full, `wr_valid` = 1 for 1 cycle -> `write_enable_1` = 0, pointers unchanged, `overflow` = 1 and stays 1; `ovf_clr` pulse -> 0 the next edge.
- Drain sync: from full, set `read_ptr_gray` = 4'b0001 (read pointer binary 1) before edge N -> `full` = 1 through N+1, 0 after N+2, `fill_level` = 7.
- Wrap: with `read_ptr_gray` tracking writes, 16 writes -> `write_addr` sequence 0..15 then 0; `write_ptr_gray` Hamming distance 1 on every change.
- Simultaneous: `wr_valid` & `full` & `ovf_clr` on the same edge -> `overflow` = 1.
